normalize_round: RTL
====================

# normalize_round

Post-addition normalize-and-round datapath for the fixed-point/FP adder. It sits directly downstream of the mantissa adder and is sequenced cycle-by-cycle by the `Control` FSM through `SREn`, `SLEn`, `NoShift`, `ShiftAmount`, `SelMuxR` and `FlagResult`. It returns `roundedMant` to `Control` for its ROUND-vs-RESULT decision. It also packs and holds the final sign/exponent/fraction word.

## Interface
Parameters:
- `EXPBITS`, 8, exponent width
- `MANTISSABITS`, 23, stored fraction width

Ports:
- `Clock`  in  1  sole clock
- `Reset`  in  1  asynchronous, active-high
- `LoadSum`  in  1  capture adder result this cycle
- `SumMant`  in  MANTISSABITS+2  adder sum; bit 24 is carry, bit 23 is hidden one
- `SumGRS`  in  3  guard/round/sticky bits from the alignment shifter
- `SumExp`  in  EXPBITS  pre-normalization exponent
- `SumSign`  in  1  result sign
- `SREn`, `SLEn`, `NoShift`, `SelMuxR`, `FlagResult`  in  1 each  from `Control`
- `ShiftAmount`  in  $clog2(MANTISSABITS)  left-shift distance
- `roundedMant`  out  MANTISSABITS+2  combinational rounded mantissa, to `Control`
- `Result`  out  1+EXPBITS+MANTISSABITS  packed {sign, exp, fraction}
- `ResultValid`  out  1  Result holds a completed sum
- `Overflow`, `Underflow`  out  1 each  sticky status for the current Result

## Operation
- Registers:
  - `Mant` (25 bits)
  - `GRS` (3 bits)
  - `Exp` (EXPBITS+1 bits, extra bit for range detection)
  - `Sign`
  - output registers
- Per-cycle priority: `LoadSum` > (`SelMuxR`&`SREn`) > `SREn` > `SLEn` > `NoShift` > hold.
- LoadSum: `Mant`<=`SumMant`, `GRS`<=`SumGRS`, `Exp`<={0,`SumExp`}, `Sign`<=`SumSign`; clears `ResultValid`, `Overflow`, `Underflow`.
- Normalized value N (combinational):
  - SREn: `Mant`>>1, new GRS = {`Mant`[0], G, R|S}, exp+1.
  - SLEn: {`Mant`,GRS} << `ShiftAmount` with zero fill, exp−`ShiftAmount`.
  - NoShift / hold: unchanged.
- `roundedMant` = RNE(N): increment when G & (R | S | N.Mant[0]).
  - Carry out of the increment lands in bit 24; `Control` reads this bit in the same cycle.
- Edge with SREn (SelMuxR=0), SLEn or NoShift: `Mant`<=`roundedMant`, `GRS`<=0, `Exp`<=N.exp.
- ROUND (SelMuxR=1 with SREn): `Mant`<=`Mant`>>1, `Exp`+1. No re-rounding is needed because the bits shifted out are zero.
- Zero: `Mant`==0 and `GRS`==0 after NoShift forces `Exp`<=0.
- Underflow: a left shift with `Exp` <= `ShiftAmount` sets `Underflow`; the packed result becomes {Sign, 0, 0}.
- Overflow: `Exp` >= 2^EXPBITS−1 after any update sets `Overflow`; the packed result becomes {Sign, all-ones, 0}.
- FlagResult: on the next edge, `Result`<={`Sign`,`Exp`[EXPBITS-1:0],`Mant`[22:0]} (with the overflow/underflow override) and `ResultValid`<=1.
  - `Result` and `ResultValid` hold until the next `LoadSum` or reset.

## Timing
- Reset (async) clears every register. Every output is 0 while in reset, including `roundedMant` (a function of zeroed registers).
- `roundedMant` has zero latency from the enables and registers; no register sits in the `Control` loop.
- LoadSum, then one normalize cycle (SR/SL/NOSHIFT), an optional ROUND cycle, then RESULT. `ResultValid` rises 1 cycle after `FlagResult`.
- LoadSum coinciding with `FlagResult`: LoadSum wins and `ResultValid` stays 0.
- Multiple enables asserted together: the priority above applies (protocol error, no assertion).
- Reset mid-operation aborts immediately. No partial `Result` is ever flagged valid.

## Structure
- The shared package `fpaddpkg` holds:
  - `INDEXCARRY`=24
  - `INDEXONE`=23
  - `GRSBITS`=3
  - a packed struct typedef for the {sign, exp, frac} result
- `Control` imports the same constants.
- Sub-module `rne_rounder`: purely combinational. Input is {mantissa, GRS}; outputs are the rounded 25-bit mantissa and a carry flag.

## Test plan
- Assert `Reset` asynchronously mid-sum → all outputs 0 immediately; `ResultValid` stays 0 after release.
- `SumMant`=25'h1800000, GRS=000, Exp=8'h80, SREn for 1 cycle, then FlagResult:
  - `roundedMant`=25'h0C00000 during SREn.
  - `Result`={0,8'h81,23'h400000}, `ResultValid`=1.
- `SumMant`=25'h0FFFFFF, GRS=100, Exp=8'h7F, NoShift → `roundedMant`=25'h1000000. Then SelMuxR+SREn, then FlagResult → `Result`={0,8'h80,0}.
- Tie-to-even: `SumMant`=25'h0800000, GRS=100, NoShift → `roundedMant`=25'h0800000. With `SumMant`=25'h0800001 → 25'h0800002.
- `SumMant`=25'h0000100, Exp=8'h90, SLEn with `ShiftAmount`=15 → `Mant`=25'h0800000, `Result` exp 8'h81.
  - Same case with Exp=8'h05 → `Underflow`=1, `Result`={sign,0,0}.
- Overflow: Exp=8'hFE, `SumMant`=25'h1000000, SREn, then FlagResult → `Overflow`=1, `Result`={sign,8'hFF,0}. A following LoadSum clears `Overflow` and `ResultValid`.

Source files
------------

// File: rtl/fpaddpkg.sv
// Shared constants and result layout for the FP adder datapath and its Control FSM.
package fpaddpkg;
  localparam int INDEXCARRY  = 24;
  localparam int INDEXONE    = 23;
  localparam int GRSBITS     = 3;
  localparam int FP_EXPBITS  = 8;
  localparam int FP_FRACBITS = 23;

  // Packed {sign, exponent, fraction} word as driven on Result.
  typedef struct packed {
    logic                   sign;
    logic [FP_EXPBITS-1:0]  exp;
    logic [FP_FRACBITS-1:0] frac;
  } fp_result_t;
endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even of a mantissa given its guard/round/sticky bits.
module rne_rounder
  import fpaddpkg::*;
#(
  parameter int MW = 25
) (
  input  logic [MW-1:0]      i_mant,
  input  logic [GRSBITS-1:0] i_grs,
  output logic [MW-1:0]      o_mant,
  output logic               o_carry
);
  logic w_inc;

  // Round up above the halfway point, and on an exact tie only when the lsb is odd.
  assign w_inc = i_grs[2] & (i_grs[1] | i_grs[0] | i_mant[0]);

  // o_carry is the carry out of the full mantissa field (value not representable).
  assign {o_carry, o_mant} = {1'b0, i_mant} + {{MW{1'b0}}, w_inc};
endmodule

// File: rtl/normalize_round.sv
// Post-addition normalize / round / pack stage, stepped cycle by cycle by Control.
module normalize_round
  import fpaddpkg::*;
#(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              LoadSum,
  input  logic [MANTISSABITS+1:0]           SumMant,
  input  logic [GRSBITS-1:0]                SumGRS,
  input  logic [EXPBITS-1:0]                SumExp,
  input  logic                              SumSign,
  input  logic                              SREn,
  input  logic                              SLEn,
  input  logic                              NoShift,
  input  logic                              SelMuxR,
  input  logic                              FlagResult,
  input  logic [$clog2(MANTISSABITS)-1:0]   ShiftAmount,
  output logic [MANTISSABITS+1:0]           roundedMant,
  output logic [EXPBITS+MANTISSABITS:0]     Result,
  output logic                              ResultValid,
  output logic                              Overflow,
  output logic                              Underflow
);
  localparam int MW = MANTISSABITS + 2;
  localparam int EW = EXPBITS + 1;
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXPBITS{1'b1}}};

  logic [MW-1:0]      r_mant;
  logic [GRSBITS-1:0] r_grs;
  logic [EW-1:0]      r_exp;
  logic               r_sign;
  logic [EXPBITS+MANTISSABITS:0] r_result;
  logic               r_valid, r_ovf, r_unf;

  logic [MW-1:0]      w_n_mant, w_rnd_mant;
  logic [GRSBITS-1:0] w_n_grs;
  logic [EW-1:0]      w_n_exp;
  logic               w_rnd_carry;
  logic               w_sr, w_sl, w_ns, w_round;
  logic               w_unf, w_zero, w_ovf;
  logic [EXPBITS+MANTISSABITS:0] w_packed;

  // Decode the enables with the fixed priority SR > SL > NoShift.
  assign w_round = SREn & SelMuxR;
  assign w_sr    = SREn;
  assign w_sl    = SLEn & ~SREn;
  assign w_ns    = NoShift & ~SREn & ~SLEn;

  // Normalized value N: right shift folds R|S into sticky, left shift zero-fills.
  always_comb begin
    w_n_mant = r_mant;
    w_n_grs  = r_grs;
    w_n_exp  = r_exp;
    if (w_sr) begin
      w_n_mant = r_mant >> 1;
      w_n_grs  = {r_mant[0], r_grs[2], r_grs[1] | r_grs[0]};
      w_n_exp  = r_exp + 1'b1;
    end else if (w_sl) begin
      {w_n_mant, w_n_grs} = {r_mant, r_grs} << ShiftAmount;
      w_n_exp  = r_exp - EW'(ShiftAmount);
    end
  end

  rne_rounder #(.MW(MW)) u_rnd (
    .i_mant  (w_n_mant),
    .i_grs   (w_n_grs),
    .o_mant  (w_rnd_mant),
    .o_carry (w_rnd_carry)
  );

  // Combinational so Control sees the carry into the top bit in the same cycle.
  assign roundedMant = w_rnd_mant;

  // Left shift past the smallest normal exponent; exactly-zero result after NoShift.
  assign w_unf  = w_sl & (r_exp <= EW'(ShiftAmount));
  assign w_zero = w_ns & (r_mant == '0) & (r_grs == '0);
  // A rounding carry out of the whole field cannot be represented either.
  assign w_ovf  = ~w_unf & ~w_zero & ((w_n_exp >= EXP_MAX) | w_rnd_carry);

  // Final word, with underflow flushing to zero and overflow saturating to infinity.
  always_comb begin
    w_packed = {r_sign, r_exp[EXPBITS-1:0], r_mant[MANTISSABITS-1:0]};
    if (r_unf)      w_packed = {r_sign, {EXPBITS{1'b0}}, {MANTISSABITS{1'b0}}};
    else if (r_ovf) w_packed = {r_sign, {EXPBITS{1'b1}}, {MANTISSABITS{1'b0}}};
  end

  // Working registers and sticky status, updated by the highest-priority command.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mant <= '0;
      r_grs  <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (LoadSum) begin
      r_mant <= SumMant;
      r_grs  <= SumGRS;
      r_exp  <= {1'b0, SumExp};
      r_sign <= SumSign;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (w_round) begin
      // Mantissa was just rounded, so the bit shifted out here is always zero.
      r_mant <= r_mant >> 1;
      r_exp  <= w_n_exp;
      if (w_n_exp >= EXP_MAX) r_ovf <= 1'b1;
    end else if (w_sr | w_sl | w_ns) begin
      r_mant <= w_rnd_mant;
      r_grs  <= '0;
      r_exp  <= (w_unf | w_zero) ? '0 : w_n_exp;
      if (w_unf) r_unf <= 1'b1;
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  // Output word: captured on FlagResult, invalidated by a new LoadSum.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else if (LoadSum) begin
      r_valid  <= 1'b0;
    end else if (FlagResult) begin
      r_result <= w_packed;
      r_valid  <= 1'b1;
    end
  end

  assign Result      = r_result;
  assign ResultValid = r_valid;
  assign Overflow    = r_ovf;
  assign Underflow   = r_unf;
endmodule
